// File: rtl/instr_prefetch_if.sv
// Handshake bundle between the instruction prefetch unit, the Execute
// redirect source, the Fetch stage consumer and instruction memory.
interface instr_prefetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    // Prefetch unit side: issues memory requests, presents the queue head.
    modport master (
        input  redirect_valid, redirect_pc, instr_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr, pc, pc_plus4,
               mem_req_valid, mem_req_addr
    );

    // Environment side: Execute/Fetch stages and instruction memory.
    modport slave (
        output redirect_valid, redirect_pc, instr_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr, pc, pc_plus4,
               mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: keeps up to DEPTH fetched {pc, instr} pairs
// ahead of the Fetch stage, reserving queue space for every request in
// flight so memory responses never need backpressure. A redirect flushes
// the queue and drops responses still owed for the old stream.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    instr_prefetch_if.master bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic              r_run;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_rsp_pc;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_out;
    logic [CW-1:0]     r_discard;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic [31:0]       r_fifo_instr [DEPTH];

    logic              w_redirect;
    logic [31:0]       w_redirect_pc;
    logic [CW:0]       w_inflight;
    logic              w_req_fire;
    logic              w_rsp;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_out_next;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    // Queued entries plus requests in flight (including ones to be dropped)
    // must stay within DEPTH, so every kept response has a free slot.
    assign w_inflight        = {1'b0, r_count} + {1'b0, r_out};
    assign bus.mem_req_valid = r_run & ~w_redirect & (w_inflight < LIMIT);
    assign bus.mem_req_addr  = r_fetch_pc;

    assign w_req_fire = bus.mem_req_valid & bus.mem_req_ready;
    // A response with nothing outstanding is stray (e.g. across a reset).
    assign w_rsp      = bus.mem_rsp_valid & (r_out != '0);
    assign w_push     = w_rsp & (r_discard == '0) & ~w_redirect;
    assign w_pop      = (r_count != '0) & bus.instr_ready & ~w_redirect;

    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = r_fifo_instr[r_rptr];
    assign bus.pc          = r_fifo_pc[r_rptr];
    assign bus.pc_plus4    = r_fifo_pc[r_rptr] + 32'd4;

    // Outstanding count after this cycle's accepts and responses.
    always_comb begin
        w_out_next = r_out;
        if (w_req_fire) begin
            w_out_next = w_out_next + CW'(1);
        end
        if (w_rsp) begin
            w_out_next = w_out_next - CW'(1);
        end
    end

    // Control state: fetch address, occupancy, pointers and drop accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            r_rsp_pc   <= RESET_PC & 32'hFFFF_FFFC;
            r_count    <= '0;
            r_out      <= '0;
            r_discard  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_run <= 1'b1;
            r_out <= w_out_next;
            if (w_redirect) begin
                // Everything still owed by memory belongs to the old stream.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_discard  <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_wptr   <= r_wptr + AW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage: responses return in order, so the kept response always
    // belongs to the next sequential address since the last redirect.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]    <= r_rsp_pc;
            r_fifo_instr[r_wptr] <= bus.mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with an in-order latency memory model
// and a pop monitor that tracks the expected pc stream.
module tb_instr_prefetch;
    logic clk;
    logic reset;

    instr_prefetch_if bus();

    instr_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks;
    int          n_pass;
    int          n_req;
    int          n_pops;
    int          cyc;
    int          lat_min;
    int          lat_max;
    bit          rand_ready;
    bit          mon_en;
    logic [31:0] exp_pc;
    logic [31:0] q_addr[$];
    int          q_due[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then advance the memory model.
    task automatic tick();
        logic        fire;
        logic [31:0] faddr;
        logic        rsp;
        int          lat;
        @(negedge clk);
        fire  = bus.mem_req_valid & bus.mem_req_ready;
        faddr = bus.mem_req_addr;
        rsp   = bus.mem_rsp_valid;
        if (mon_en && ((bus.instr_valid & bus.instr_ready & ~bus.redirect_valid) === 1'b1)) begin
            check("pop_pc", bus.pc, exp_pc);
            check("pop_instr", bus.instr, mem_word(exp_pc));
            check("pop_pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (fire === 1'b1) n_req++;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp === 1'b1 && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (fire === 1'b1) begin
            lat = int'($urandom_range(lat_max, lat_min));
            q_addr.push_back(faddr);
            q_due.push_back(cyc - 1 + lat);
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(q_addr[0]);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = 32'h0;
        end
        if (rand_ready) bus.mem_req_ready = 1'($urandom_range(1, 0));
    endtask

    // Reset (memory is reset alongside), then release; leaves us in cycle 0.
    task automatic do_reset();
        mon_en             = 1'b0;
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        tick();
        tick();
        q_addr.delete();
        q_due.delete();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        #1;
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        reset  = 1'b1;
        exp_pc = 32'h0;
        n_req  = 0;
        n_pops = 0;
        mon_en = 1'b1;
        #1;
        check("post_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        #1;
        check("redir_req_gate", 32'(bus.mem_req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = target & 32'hFFFF_FFFC;
        #1;
        check("redir_flush", 32'(bus.instr_valid), 32'd0);
        check("redir_first_addr", bus.mem_req_addr, exp_pc);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        n_checks          = 0;
        n_pass            = 0;
        cyc               = 0;
        lat_min           = 1;
        lat_max           = 1;
        rand_ready        = 1'b0;
        mon_en            = 1'b0;
        exp_pc            = 32'h0;
        reset             = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus.instr_ready   = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;

        // Reset release, 1-cycle memory, consumer always ready.
        do_reset();
        bus.instr_ready = 1'b1;
        tick(); #1;
        check("c1_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("c1_req_addr", bus.mem_req_addr, 32'h0);
        tick(); #1;
        check("c2_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("c2_req_addr", bus.mem_req_addr, 32'h4);
        tick(); #1;
        check("c3_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("c3_pc", bus.pc, 32'h0);
        check("c3_req_addr", bus.mem_req_addr, 32'h8);
        n_pops = 0;
        repeat (8) tick();
        check("stream_pops", n_pops, 32'd8);

        // Consumer stalled: queue fills to DEPTH, requests stop until a pop.
        do_reset();
        bus.instr_ready = 1'b0;
        repeat (12) tick();
        #1;
        check("stall_req_count", n_req, 32'd4);
        check("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("stall_head_pc", bus.pc, 32'h0);
        bus.instr_ready = 1'b1;
        tick(); #1;
        check("unstall_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("unstall_req_addr", bus.mem_req_addr, 32'h10);

        // Redirect with three requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        bus.instr_ready = 1'b1;
        repeat (4) tick();
        #1;
        check("lat3_req_count", n_req, 32'd3);
        check("lat3_instr_valid", 32'(bus.instr_valid), 32'd0);
        do_redirect(32'h0000_0100);
        check("lat3_redir_req_valid", 32'(bus.mem_req_valid), 32'd1);
        wait_valid(n);
        check("lat3_redir_latency", n, 32'd4);
        check("lat3_redir_pc", bus.pc, 32'h0000_0100);
        repeat (8) tick();

        // Redirect in a cycle with a pop and a response both active.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        bus.instr_ready = 1'b1;
        repeat (6) tick();
        #1;
        check("busy_instr_valid", 32'(bus.instr_valid), 32'd1);
        do_redirect(32'h0000_0200);
        check("busy_redir_req_valid", 32'(bus.mem_req_valid), 32'd1);
        wait_valid(n);
        check("busy_redir_latency", n, 32'd2);
        check("busy_redir_pc", bus.pc, 32'h0000_0200);
        repeat (4) tick();

        // Fetch address wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        tick(); #1;
        check("wrap_req_addr", bus.mem_req_addr, 32'h0);
        wait_valid(n);
        check("wrap_latency", n, 32'd1);
        check("wrap_head_pc", bus.pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        repeat (4) tick();

        // Misaligned redirect target is word-aligned.
        do_redirect(32'h0000_0303);
        repeat (6) tick();

        // Random memory acceptance, latency and consumer stalls, with
        // occasional redirects.
        rand_ready = 1'b1;
        lat_min    = 1;
        lat_max    = 5;
        n_pops     = 0;
        for (int i = 0; i < 400; i++) begin
            bus.instr_ready = 1'($urandom_range(1, 0));
            if ($urandom_range(39, 0) == 0) begin
                do_redirect($urandom());
            end else begin
                tick();
            end
        end
        rand_ready        = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.instr_ready   = 1'b1;
        repeat (30) tick();
        check("rand_progress", 32'(n_pops > 40), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
